// File: rtl/pool_window_gen.sv
// pool_window_gen: raster pixel stream to packed non-overlapping 2x2 windows for max pooling.
module pool_window_gen #(
  parameter int BUF_WIDTH    = 26,
  parameter int POOLING_SIZE = 2,
  parameter int FM_WIDTH     = 24,
  parameter int FM_HEIGHT    = 24,
  localparam int CW = FM_WIDTH  > 1 ? $clog2(FM_WIDTH)  : 1,
  localparam int RW = FM_HEIGHT > 1 ? $clog2(FM_HEIGHT) : 1
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        in_valid,
  input  logic                                        in_sof,
  input  logic [BUF_WIDTH-1:0]                        in_data,
  output logic                                        start,
  output logic [BUF_WIDTH*POOLING_SIZE*POOLING_SIZE-1:0] ifm,
  output logic                                        frame_done,
  output logic [CW-1:0]                               col_idx,
  output logic [RW-1:0]                               row_idx
);
  typedef enum logic {S_FILL, S_EMIT} state_t;
  state_t state_q, state_d, st;
  logic [CW-1:0] col_q, col_d, c;
  logic [RW-1:0] row_q, row_d, r;
  logic [BUF_WIDTH-1:0] hold_q, hold_d;
  logic [BUF_WIDTH*POOLING_SIZE*POOLING_SIZE-1:0] ifm_q, ifm_d;
  logic start_q, start_d, done_q, done_d;
  logic last_col, last_row, fire;
  logic [BUF_WIDTH-1:0] linebuf [FM_WIDTH];
  always_comb begin
    c        = in_sof ? '0 : col_q;
    r        = in_sof ? '0 : row_q;
    st       = in_sof ? S_FILL : state_q;
    last_col = c == CW'(FM_WIDTH - 1);
    last_row = r == RW'(FM_HEIGHT - 1);
    fire     = in_valid && st == S_EMIT && c[0];
    col_d    = col_q;
    row_d    = row_q;
    state_d  = state_q;
    hold_d   = hold_q;
    if (in_valid) begin
      col_d   = last_col ? '0 : c + CW'(1);
      row_d   = last_col ? (last_row ? '0 : r + RW'(1)) : r;
      // a trailing odd row sits in S_FILL, so the frame wrap must force S_FILL
      state_d = !last_col ? st : last_row ? S_FILL : st == S_FILL ? S_EMIT : S_FILL;
      hold_d  = (st == S_EMIT && !c[0]) ? in_data : hold_q;
    end
    ifm_d   = fire ? {in_data, hold_q, linebuf[c], linebuf[c & ~CW'(1)]} : ifm_q;
    start_d = fire;
    done_d  = in_valid && last_col && last_row;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FILL;
      col_q   <= '0;
      row_q   <= '0;
      hold_q  <= '0;
      ifm_q   <= '0;
      start_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      hold_q  <= hold_d;
      ifm_q   <= ifm_d;
      start_q <= start_d;
      done_q  <= done_d;
    end
  end
  always_ff @(posedge clk) begin
    if (in_valid && st == S_FILL) linebuf[c] <= in_data;
  end
  assign start      = start_q;
  assign ifm        = ifm_q;
  assign frame_done = done_q;
  assign col_idx    = col_q;
  assign row_idx    = row_q;
endmodule

// File: tb/tb_pool_window_gen.sv
// tb_pool_window_gen: 4x4 and 5x5 instances checked by a vector table and a window scoreboard.
module tb_pool_window_gen;
  logic clk = 0, rst = 1, v4 = 0, v5 = 0, sof = 0;
  logic [25:0] din = '0;
  logic st4, st5, fd4, fd5;
  logic [103:0] ifm4, ifm5;
  logic [1:0] c4, r4;
  logic [2:0] c5, r5;
  int cyc = 0, checks = 0, errors = 0, pr = 0, pc = 0;
  logic [25:0] img [5][5];
  typedef struct {logic [103:0] w; int cyc;} exp_t;
  typedef struct {logic [25:0] d; logic s; logic [103:0] f; logic fd;} vec_t;
  exp_t wq4[$], wq5[$];
  int dq4[$], dq5[$];
  vec_t tv[16];

  pool_window_gen #(.BUF_WIDTH(26), .POOLING_SIZE(2), .FM_WIDTH(4), .FM_HEIGHT(4)) u4 (
    .clk(clk), .rst(rst), .in_valid(v4), .in_sof(sof), .in_data(din),
    .start(st4), .ifm(ifm4), .frame_done(fd4), .col_idx(c4), .row_idx(r4));
  pool_window_gen #(.BUF_WIDTH(26), .POOLING_SIZE(2), .FM_WIDTH(5), .FM_HEIGHT(5)) u5 (
    .clk(clk), .rst(rst), .in_valid(v5), .in_sof(sof), .in_data(din),
    .start(st5), .ifm(ifm5), .frame_done(fd5), .col_idx(c5), .row_idx(r5));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [103:0] win(int a, int b, int c, int d);
    return {26'(d), 26'(c), 26'(b), 26'(a)};
  endfunction

  task automatic chk(input string n, input logic [103:0] a, input logic [103:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h exp %h (cyc %0d)", n, a, e, cyc);
    end
  endtask

  task automatic mon(input int sel, input logic s, input logic [103:0] f, input logic d);
    exp_t e;
    bit have;
    int dc;
    have = sel ? wq5.size() > 0 : wq4.size() > 0;
    if (have) e = sel ? wq5[0] : wq4[0];
    if (s) begin
      checks++;
      if (!have) begin
        errors++;
        $display("FAIL spurious_start dut%0d cyc %0d ifm %h", sel, cyc, f);
      end else begin
        if (sel) void'(wq5.pop_front()); else void'(wq4.pop_front());
        if (e.cyc != cyc || e.w !== f) begin
          errors++;
          $display("FAIL window dut%0d got %h at cyc %0d exp %h at cyc %0d", sel, f, cyc, e.w, e.cyc);
        end
      end
    end else if (have && e.cyc <= cyc) begin
      checks++;
      errors++;
      $display("FAIL missing_start dut%0d exp %h at cyc %0d", sel, e.w, e.cyc);
      if (sel) void'(wq5.pop_front()); else void'(wq4.pop_front());
    end
    have = sel ? dq5.size() > 0 : dq4.size() > 0;
    if (have) dc = sel ? dq5[0] : dq4[0];
    if (d) begin
      checks++;
      if (!have || dc != cyc) begin
        errors++;
        $display("FAIL frame_done dut%0d got pulse at cyc %0d exp cyc %0d", sel, cyc, have ? dc : -1);
      end
      if (have) begin
        if (sel) void'(dq5.pop_front()); else void'(dq4.pop_front());
      end
    end else if (have && dc <= cyc) begin
      checks++;
      errors++;
      $display("FAIL missing_frame_done dut%0d exp cyc %0d", sel, dc);
      if (sel) void'(dq5.pop_front()); else void'(dq4.pop_front());
    end
  endtask

  always @(negedge clk) begin
    mon(0, st4, ifm4, fd4);
    mon(1, st5, ifm5, fd5);
  end

  task automatic do_reset();
    rst = 1; v4 = 0; v5 = 0; sof = 0;
    @(posedge clk); #1;
    rst = 0; pr = 0; pc = 0;
    chk("rst_start4", 104'(st4), 0);
    chk("rst_done4", 104'(fd4), 0);
    chk("rst_ifm4", ifm4, 0);
    chk("rst_col4", 104'(c4), 0);
    chk("rst_row4", 104'(r4), 0);
    chk("rst_start5", 104'(st5), 0);
    chk("rst_ifm5", ifm5, 0);
    chk("rst_col5", 104'(c5), 0);
    chk("rst_row5", 104'(r5), 0);
  endtask

  task automatic drive_px(input int sel, input logic [25:0] d, input logic s, input int gap);
    int w, h;
    exp_t e;
    w = sel ? 5 : 4;
    h = sel ? 5 : 4;
    if (s) begin pr = 0; pc = 0; end
    img[pr][pc] = d;
    din = d; sof = s;
    if (sel) v5 = 1; else v4 = 1;
    @(posedge clk); #1;
    v4 = 0; v5 = 0; sof = 0;
    if (pr % 2 == 1 && pc % 2 == 1) begin
      e.w = {img[pr][pc], img[pr][pc-1], img[pr-1][pc], img[pr-1][pc-1]};
      e.cyc = cyc;
      if (sel) wq5.push_back(e); else wq4.push_back(e);
    end
    if (pr == h - 1 && pc == w - 1) begin
      if (sel) dq5.push_back(cyc); else dq4.push_back(cyc);
    end
    pc = pc + 1;
    if (pc == w) begin pc = 0; pr = (pr + 1) % h; end
    for (int g = 0; g <= gap; g++) begin
      if (g > 0) begin @(posedge clk); #1; end
      chk("col_idx", sel ? 104'(c5) : 104'(c4), 104'(pc));
      chk("row_idx", sel ? 104'(r5) : 104'(r4), 104'(pr));
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      tv[i].d  = 26'(i);
      tv[i].s  = (i == 5 || i == 7 || i == 13 || i == 15);
      tv[i].f  = i < 5 ? '0 : i < 7 ? win(0, 1, 4, 5) : i < 13 ? win(2, 3, 6, 7) :
                 i < 15 ? win(8, 9, 12, 13) : win(10, 11, 14, 15);
      tv[i].fd = (i == 15);
    end
    do_reset();
    for (int i = 0; i < 16; i++) begin
      drive_px(0, tv[i].d, 1'b0, 0);
      chk("t1_start", 104'(st4), 104'(tv[i].s));
      chk("t1_ifm", ifm4, tv[i].f);
      chk("t1_done", 104'(fd4), 104'(tv[i].fd));
    end
    do_reset();
    for (int i = 0; i < 16; i++) drive_px(0, 26'(i), 1'b0, 1);
    do_reset();
    for (int i = 0; i < 16; i++) begin
      drive_px(0, i == 5 ? 26'h3FFFFFD : 26'(i), 1'b0, 0);
      if (i == 5) chk("t3_slot3_neg", 104'(ifm4[103:78]), 104'(26'h3FFFFFD));
    end
    do_reset();
    for (int i = 0; i <= 6; i++) drive_px(0, 26'(i), 1'b0, 0);
    do_reset();
    for (int i = 100; i < 116; i++) drive_px(0, 26'(i), 1'b0, 0);
    do_reset();
    for (int i = 0; i <= 8; i++) drive_px(0, 26'(i), 1'b0, 0);
    drive_px(0, 26'd50, 1'b1, 0);
    for (int i = 51; i <= 65; i++) drive_px(0, 26'(i), 1'b0, 0);
    do_reset();
    for (int i = 0; i < 25; i++) drive_px(1, 26'(i), 1'b0, 0);
    chk("t6_done", 104'(fd5), 1);
    chk("t6_no_start", 104'(st5), 0);
    repeat (3) @(posedge clk);
    #1;
    chk("pending_windows", 104'(wq4.size() + wq5.size()), 0);
    chk("pending_done", 104'(dq4.size() + dq5.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
